// File: rtl/snoop_bus_pkg.sv
// rtl/snoop_bus_pkg.sv - shared types and sizes for the coherence snoop bus
package snoop_bus_pkg;

    localparam int TAG_W            = 8;
    localparam int IDX_W            = 5;
    localparam int SNOOP_RSPQ_DEPTH = 4;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        GET_S = 2'd1,
        GET_M = 2'd2,
        PUT_M = 2'd3
    } message_t;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } stage_state_t;

    typedef struct packed {
        logic        vld;
        logic        id;
        logic        dvld;
        logic [3:0]  memtag;
        logic [63:0] data;
    } rspq_entry_t;

    function automatic logic [63:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        line_addr = {{(64-TAG_W-IDX_W-3){1'b0}}, tag, idx, 3'b000};
    endfunction

endpackage

// File: rtl/snoop_bus_rspq.sv
// rtl/snoop_bus_rspq.sv - in-order GET_S response queue with memory-tag fill
module snoop_bus_rspq
    import snoop_bus_pkg::*;
#(
    parameter int DEPTH = SNOOP_RSPQ_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc_en,
    input  logic        alloc_id,
    input  logic        alloc_dvld,
    input  logic [3:0]  alloc_memtag,
    input  logic [63:0] alloc_data,
    input  logic [3:0]  fill_tag,
    input  logic [63:0] fill_data,
    input  logic [1:0]  ack,
    output logic        full,
    output logic        head_vld,
    output logic        head_id,
    output logic [63:0] head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    rspq_entry_t entries [DEPTH];
    logic [PW:0]   head_ptr;
    logic [PW:0]   tail_ptr;
    logic [PW-1:0] head_slot;
    logic [PW-1:0] tail_slot;
    logic          pop;

    assign head_slot = head_ptr[PW-1:0];
    assign tail_slot = tail_ptr[PW-1:0];
    assign full      = (head_ptr[PW] != tail_ptr[PW]) && (head_slot == tail_slot);
    assign head_vld  = entries[head_slot].vld & entries[head_slot].dvld;
    assign head_id   = entries[head_slot].id;
    assign head_data = entries[head_slot].data;
    // Only the owning cpu may consume the head; the other ack is ignored.
    assign pop       = head_vld & ack[entries[head_slot].id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (fill_tag != 4'd0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entries[i].vld && !entries[i].dvld && entries[i].memtag == fill_tag) begin
                        entries[i].dvld <= 1'b1;
                        entries[i].data <= fill_data;
                    end
                end
            end
            if (pop) begin
                entries[head_slot].vld <= 1'b0;
                head_ptr               <= head_ptr + PTR_ONE;
            end
            // Caller never allocates while full, so tail never aliases head here.
            if (alloc_en) begin
                entries[tail_slot] <= '{vld: 1'b1, id: alloc_id, dvld: alloc_dvld,
                                        memtag: alloc_memtag, data: alloc_data};
                tail_ptr           <= tail_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/snoop_bus.sv
// rtl/snoop_bus.sv - two-cpu snoop bus: round-robin stage, memory mux, response queue
module snoop_bus
    import snoop_bus_pkg::*;
#(
    parameter int RSPQ_DEPTH = SNOOP_RSPQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            Dctrl2bus_req_en_i,
    input  logic [1:0][TAG_W-1:0] Dctrl2bus_req_tag_i,
    input  logic [1:0][IDX_W-1:0] Dctrl2bus_req_idx_i,
    input  logic [1:0][63:0]      Dctrl2bus_req_data_i,
    input  logic [1:0][1:0]       Dctrl2bus_req_message_i,
    input  logic [1:0]            Dctrl2bus_rsp_vld_i,
    input  logic [1:0][63:0]      Dctrl2bus_rsp_data_i,
    input  logic [1:0]            Dctrl2bus_rsp_ack_i,
    output logic                  bus2Dctrl_req_ack_o,
    output logic                  bus2Dctrl_req_id_o,
    output logic [TAG_W-1:0]      bus2Dctrl_req_tag_o,
    output logic [IDX_W-1:0]      bus2Dctrl_req_idx_o,
    output message_t              bus2Dctrl_req_message_o,
    output logic                  bus2Dctrl_rsp_vld_o,
    output logic                  bus2Dctrl_rsp_id_o,
    output logic [63:0]           bus2Dctrl_rsp_data_o,
    output bus_command_t          proc2mem_command_o,
    output logic [63:0]           proc2mem_addr_o,
    output logic [63:0]           proc2mem_data_o,
    input  logic [3:0]            mem2proc_response_i,
    input  logic [63:0]           mem2proc_data_i,
    input  logic [3:0]            mem2proc_tag_i
);

    stage_state_t     state;
    logic             rr_ptr;
    logic             stage_id;
    logic [TAG_W-1:0] stage_tag;
    logic [IDX_W-1:0] stage_idx;
    logic [63:0]      stage_data;
    message_t         stage_msg;

    logic             grant_id;
    logic             peer_hit;
    logic             owner_abort;
    logic             commit;
    logic             alloc_en;
    logic             alloc_dvld;
    logic             q_full;
    bus_command_t     command;

    assign grant_id    = Dctrl2bus_req_en_i[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign peer_hit    = Dctrl2bus_rsp_vld_i[~stage_id];
    assign owner_abort = !Dctrl2bus_req_en_i[stage_id]
                       || (Dctrl2bus_req_tag_i[stage_id] != stage_tag)
                       || (Dctrl2bus_req_idx_i[stage_id] != stage_idx)
                       || (Dctrl2bus_req_message_i[stage_id] != stage_msg);

    always_comb begin
        command    = BUS_NONE;
        commit     = 1'b0;
        alloc_en   = 1'b0;
        alloc_dvld = 1'b0;
        if (state == ST_HOLD && !owner_abort) begin
            case (stage_msg)
                GET_M: commit = 1'b1;
                PUT_M: begin
                    command = BUS_STORE;
                    commit  = (mem2proc_response_i != 4'd0);
                end
                GET_S: begin
                    // A full queue stalls both the peer-hit and the memory path.
                    if (!q_full) begin
                        if (peer_hit) begin
                            commit     = 1'b1;
                            alloc_en   = 1'b1;
                            alloc_dvld = 1'b1;
                        end else begin
                            command  = BUS_LOAD;
                            commit   = (mem2proc_response_i != 4'd0);
                            alloc_en = commit;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= 1'b0;
            stage_id   <= 1'b0;
            stage_tag  <= '0;
            stage_idx  <= '0;
            stage_data <= '0;
            stage_msg  <= NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|Dctrl2bus_req_en_i) begin
                        stage_id   <= grant_id;
                        stage_tag  <= Dctrl2bus_req_tag_i[grant_id];
                        stage_idx  <= Dctrl2bus_req_idx_i[grant_id];
                        stage_data <= Dctrl2bus_req_data_i[grant_id];
                        stage_msg  <= message_t'(Dctrl2bus_req_message_i[grant_id]);
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (owner_abort) begin
                        state <= ST_IDLE;
                    end else if (commit) begin
                        state  <= ST_IDLE;
                        rr_ptr <= ~stage_id;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus2Dctrl_req_ack_o     = commit;
    assign bus2Dctrl_req_id_o      = (state == ST_HOLD) ? stage_id : 1'b0;
    assign bus2Dctrl_req_tag_o     = (state == ST_HOLD) ? stage_tag : '0;
    assign bus2Dctrl_req_idx_o     = (state == ST_HOLD) ? stage_idx : '0;
    assign bus2Dctrl_req_message_o = (state == ST_HOLD) ? stage_msg : NONE;

    assign proc2mem_command_o = command;
    assign proc2mem_addr_o    = (command != BUS_NONE) ? line_addr(stage_tag, stage_idx) : 64'd0;
    assign proc2mem_data_o    = (command == BUS_STORE) ? stage_data : 64'd0;

    snoop_bus_rspq #(.DEPTH(RSPQ_DEPTH)) u_rspq (
        .clk          (clk),
        .rst          (rst),
        .alloc_en     (alloc_en),
        .alloc_id     (stage_id),
        .alloc_dvld   (alloc_dvld),
        .alloc_memtag (peer_hit ? 4'd0 : mem2proc_response_i),
        .alloc_data   (peer_hit ? Dctrl2bus_rsp_data_i[~stage_id] : 64'd0),
        .fill_tag     (mem2proc_tag_i),
        .fill_data    (mem2proc_data_i),
        .ack          (Dctrl2bus_rsp_ack_i),
        .full         (q_full),
        .head_vld     (bus2Dctrl_rsp_vld_o),
        .head_id      (bus2Dctrl_rsp_id_o),
        .head_data    (bus2Dctrl_rsp_data_o)
    );

endmodule
